// File: rtl/inst_buffer.sv
// Two-wide circular instruction buffer between fetch and decode.
// Outputs come from registered state only, so a fresh entry is visible one cycle after it is written.
module inst_buffer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [1:0]             in_valid,
   input  logic [WIDTH-1:0][31:0] in_inst,
   input  logic [WIDTH-1:0][31:0] in_pc,
   output logic                   in_ready,
   output logic [1:0]             out_valid,
   output logic [WIDTH-1:0][31:0] out_inst,
   output logic [WIDTH-1:0][31:0] out_pc,
   input  logic [1:0]             deq_count,
   output logic [CNT_W-1:0]       count
);

   logic [31:0]      mem_inst [DEPTH];
   logic [31:0]      mem_pc   [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_plus1;
   logic [PTR_W-1:0] tail_plus1;
   logic [1:0]       enq;
   logic [1:0]       deq_cap;
   logic [1:0]       deq;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   assign head_plus1 = head + PTR_W'(1);
   assign tail_plus1 = tail + PTR_W'(1);

   always_comb begin
      in_ready = (count <= CNT_W'(DEPTH - 2));
      enq      = 2'd0;
      if (in_ready && in_valid[0])
         enq = in_valid[1] ? 2'd2 : 2'd1;
      deq_cap = (deq_count > 2'd2) ? 2'd2 : deq_count;
      // Never retire more than is held; count is 0 or 1 whenever this clamps.
      deq     = (count < CNT_W'(deq_cap)) ? count[1:0] : deq_cap;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(deq);
         tail  <= tail + PTR_W'(enq);
         count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   // Payload is not reset; it is only ever seen through valid slots.
   always_ff @(posedge clock) begin
      if (!reset && !flush && enq != 2'd0) begin
         mem_inst[tail] <= in_inst[0];
         mem_pc[tail]   <= in_pc[0];
         if (enq == 2'd2) begin
            mem_inst[tail_plus1] <= in_inst[1];
            mem_pc[tail_plus1]   <= in_pc[1];
         end
      end
   end

   always_comb begin
      out_valid[0] = (count != '0);
      out_valid[1] = (count >= CNT_W'(2));
      out_inst[0]  = out_valid[0] ? mem_inst[head]       : 32'd0;
      out_pc[0]    = out_valid[0] ? mem_pc[head]         : 32'd0;
      out_inst[1]  = out_valid[1] ? mem_inst[head_plus1] : 32'd0;
      out_pc[1]    = out_valid[1] ? mem_pc[head_plus1]   : 32'd0;
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed stimulus for inst_buffer; accepted entries go into a queue and a
// negedge monitor pops them as the decoder side consumes them.
module tb_inst_buffer;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              flush = 1'b0;
   logic [1:0]        in_valid = 2'b00;
   logic [1:0][31:0]  in_inst = '0;
   logic [1:0][31:0]  in_pc = '0;
   logic              in_ready;
   logic [1:0]        out_valid;
   logic [1:0][31:0]  out_inst;
   logic [1:0][31:0]  out_pc;
   logic [1:0]        deq_count = 2'd0;
   logic [CNT_W-1:0]  count;

   inst_buffer #(.DEPTH(DEPTH), .WIDTH(2)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
      .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
      .out_pc(out_pc), .deq_count(deq_count), .count(count)
   );

   always #5 clock = ~clock;

   logic [31:0] exp_q [$];
   int          m_count = 0;
   bit          mon_en = 1'b0;
   int          n_checks = 0;
   int          n_fails = 0;
   logic [31:0] next_pc = 32'h0;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0] ^ 16'hA5C3, ~pc[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: state checks every cycle, payload checks on consumed slots.
   always @(negedge clock) begin
      if (mon_en) begin
         int exp_deq;
         logic [31:0] pc_e;
         check("count", 32'(count), 32'(m_count));
         check("in_ready", 32'(in_ready), 32'(m_count <= DEPTH - 2));
         check("out_valid", 32'(out_valid), {30'd0, m_count >= 2, m_count >= 1});
         if (m_count < 2) begin
            check("slot1_pc_zero", out_pc[1], 32'd0);
            check("slot1_inst_zero", out_inst[1], 32'd0);
         end
         if (m_count < 1) check("slot0_pc_zero", out_pc[0], 32'd0);
         exp_deq = (deq_count > 2) ? 2 : int'(deq_count);
         if (exp_deq > m_count) exp_deq = m_count;
         if (!flush) begin
            for (int i = 0; i < exp_deq; i++) begin
               if (exp_q.size() == 0) begin
                  check("queue_underrun", 32'd1, 32'd0);
               end else begin
                  pc_e = exp_q.pop_front();
                  check($sformatf("out_pc%0d", i), out_pc[i], pc_e);
                  check($sformatf("out_inst%0d", i), out_inst[i], inst_of(pc_e));
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      mon_en = 1'b0;
      in_valid = 2'b00;
      deq_count = 2'd0;
      flush = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      m_count = 0;
      exp_q.delete();
      mon_en = 1'b1;
   endtask

   // One clock of stimulus; offers next_pc/next_pc+4 when vld requests it.
   task automatic step(input bit fl, input logic [1:0] vld, input logic [1:0] dq);
      int enq;
      int dq_eff;
      bit acc;
      logic [31:0] p0;
      logic [31:0] p1;
      p0 = next_pc;
      p1 = next_pc + 32'd4;
      flush = fl;
      in_valid = vld;
      in_pc[0] = p0;
      in_pc[1] = p1;
      in_inst[0] = inst_of(p0);
      in_inst[1] = inst_of(p1);
      deq_count = dq;
      acc = (m_count <= DEPTH - 2);
      enq = acc ? (vld[0] ? (vld[1] ? 2 : 1) : 0) : 0;
      dq_eff = (dq > 2) ? 2 : int'(dq);
      if (dq_eff > m_count) dq_eff = m_count;
      @(posedge clock); #1;
      if (fl) begin
         m_count = 0;
         exp_q.delete();
      end else begin
         if (enq >= 1) exp_q.push_back(p0);
         if (enq == 2) exp_q.push_back(p1);
         m_count = m_count + enq - dq_eff;
         next_pc = next_pc + 32'(4 * enq);
      end
      flush = 1'b0;
      in_valid = 2'b00;
      deq_count = 2'd0;
   endtask

   initial begin
      @(posedge clock); #1;
      do_reset();
      // First pair at pc 0x0/0x4, then fill to full.
      step(0, 2'b11, 2'd0);
      for (int i = 0; i < 3; i++) step(0, 2'b11, 2'd0);
      check("full_count", 32'(count), 32'd8);
      check("full_ready", 32'(in_ready), 32'd0);
      // Offer pc 0x40 into a full buffer: must be dropped.
      next_pc = 32'h40;
      step(0, 2'b11, 2'd0);
      check("full_ignored", 32'(count), 32'd8);
      // Streaming across pointer wrap.
      for (int i = 0; i < 20; i++) step(0, 2'b11, 2'd2);
      // Drain to 3, then simultaneous enqueue 2 / dequeue 2.
      step(0, 2'b00, 2'd2);
      step(0, 2'b00, 2'd1);
      check("count_3", 32'(count), 32'd3);
      step(0, 2'b11, 2'd2);
      check("enq_deq_count", 32'(count), 32'd3);
      // Grow to 5 and flush with competing enqueue/dequeue.
      step(0, 2'b11, 2'd0);
      check("count_5", 32'(count), 32'd5);
      step(1, 2'b11, 2'd2);
      check("flush_count", 32'(count), 32'd0);
      check("flush_ready", 32'(in_ready), 32'd1);
      // Slot 1 alone enqueues nothing; underflow guard at count 1 and 0.
      step(0, 2'b10, 2'd0);
      check("v10_count", 32'(count), 32'd0);
      step(0, 2'b01, 2'd0);
      step(0, 2'b00, 2'd2);
      check("underflow_count", 32'(count), 32'd0);
      step(0, 2'b00, 2'd3);
      step(0, 2'b11, 2'd3);
      step(0, 2'b01, 2'd3);
      // Reset while holding entries, with pending traffic on the inputs.
      step(0, 2'b11, 2'd0);
      step(0, 2'b11, 2'd1);
      in_valid = 2'b11;
      deq_count = 2'd2;
      flush = 1'b1;
      do_reset();
      check("reset_count", 32'(count), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      step(0, 2'b11, 2'd0);
      step(0, 2'b00, 2'd2);
      step(0, 2'b00, 2'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, 8, number of entries; SHALL be a power of two, at least 4.
REQ-002 Parameter WIDTH, 2, fixed enqueue/dequeue width; SHALL be 2 in this revision.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discards all buffered entries (mispredict/exception recovery).
REQ-006 in_valid  input  2  per-slot valid from fetch; slot 0 is the older instruction.
REQ-007 in_inst  input  2x32 (inst_t)  fetched instruction words.
REQ-008 in_pc  input  2x32  PC of each fetched instruction.
REQ-009 in_ready  output  1  buffer can accept two instructions this cycle.
REQ-010 out_valid  output  2  per-slot valid toward the decoders; slot 0 is the oldest entry.
REQ-011 out_inst  output  2x32 (inst_t)  instructions presented to the decoders.
REQ-012 out_pc  output  2x32  PCs of the presented instructions.
REQ-013 deq_count  input  2  number of presented instructions consumed this cycle (0..2).
REQ-014 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage SHALL be a circular array of DEPTH {inst, pc} entries with head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 in_ready SHALL be 1 iff registered count <= DEPTH-2; it SHALL NOT depend on deq_count or flush in the same cycle.
REQ-017 Enqueue count SHALL be in_valid[0] + (in_valid[0] & in_valid[1]); in_valid=2'b10 SHALL enqueue nothing.
REQ-018 Enqueue SHALL occur only when in_ready=1; slot 0 SHALL be written at tail and slot 1 at tail+1 (mod DEPTH); tail SHALL advance by the enqueue count.
REQ-019 When in_ready=0, inputs SHALL be ignored and buffer contents SHALL be unchanged by the write side.
REQ-020 out_valid[0] SHALL be (count>=1) and out_valid[1] SHALL be (count>=2), both derived combinationally from registered state.
REQ-021 out_inst/out_pc slot 0 SHALL show the entry at head and slot 1 the entry at head+1 (mod DEPTH); invalid slots SHALL drive 0.
REQ-022 No bypass: an instruction enqueued at edge t SHALL first appear on the outputs in the cycle after edge t.
REQ-023 Effective dequeue SHALL be min(deq_count, count, 2); head SHALL advance by that amount.
REQ-024 On simultaneous enqueue and dequeue, count_next SHALL be count + enq - deq; both SHALL take effect on the same edge.
REQ-025 At count=DEPTH-2 with a 2-wide enqueue and no dequeue, the buffer SHALL become full (count=DEPTH) and in_ready SHALL be 0 the next cycle.
REQ-026 At count=0, out_valid SHALL be 2'b00 and any deq_count SHALL have no effect.
REQ-027 flush=1 SHALL have priority over enqueue and dequeue in the same cycle; at the next edge head=tail=0 and count=0, and that cycle's input instructions SHALL be dropped.
REQ-028 Outputs during the flush cycle SHALL still reflect pre-flush state; the consumer is responsible for ignoring them.
REQ-029 Entry payload registers SHALL NOT require reset; their contents SHALL be observable only through valid slots.

Reset
REQ-030 With reset=1 at a rising edge, head, tail and count SHALL be 0 after that edge, so out_valid=2'b00 and in_ready=1.
REQ-031 reset SHALL have priority over flush, enqueue and dequeue.
REQ-032 Reset asserted mid-operation SHALL discard all entries, with no partial state retained.

Verification
REQ-033 After reset, in_valid=2'b11 with pc 0x0/0x4 and deq_count=0 -> next cycle count=2, out_valid=2'b11, out_pc=0x0/0x4.
REQ-034 With deq_count=0, four 2-wide enqueues (DEPTH=8) -> count=8 and in_ready=0; a fifth enqueue at pc 0x40 -> ignored, count stays 8.
REQ-035 At count=8 (head=0), deq_count=2 each cycle with 2-wide enqueues whenever in_ready=1, run 20 cycles -> PCs leave strictly in order across pointer wrap, with no duplicates or losses.
REQ-036 At count=3, in_valid=2'b11 with deq_count=2 -> next count=3, and out_pc slot 0 = the former third entry.
REQ-037 At count=5, flush=1 with in_valid=2'b11 and deq_count=2 -> next cycle count=0, out_valid=2'b00 and in_ready=1.
REQ-038 in_valid=2'b10 -> nothing enqueued; at count=1, deq_count=2 -> count=0 with no underflow.
